pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. It decides every cycle whether the IF, ID, EX, MEM and WB registers advance, hold or take a bubble. It handles three cases: load-use hazards, ID-resolved branches and jumps, and multi-cycle data-memory accesses. It drives the ID/EX bubble mux in place of the decoder's flush line, adds a memory-wait timeout with a sticky error, and keeps saturating stall and flush counters.

---
 rtl/pipeline_ctrl_pkg.sv | 13 +
 rtl/pipeline_ctrl_sat_counter.sv | 31 +++
 rtl/pipeline_ctrl.sv | 121 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam int         CNT_W_DEFAULT = 16;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, ID redirects,
// data-memory wait freeze with timeout, and saturating stall/flush statistics.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             id_branch_i,
  input  logic             id_eq_i,
  input  logic             id_jump_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_hold_o,
  output logic             memwb_bubble_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        freeze, load_use, redirect;

  always_comb begin
    freeze   = ((state_q == RUN) && dmem_req_i && !dmem_ready_i) ||
               ((state_q == MEM_WAIT) && !dmem_ready_i) ||
               (state_q == ERROR);
    load_use = ex_memread_i && (ex_rt_i != REG_ZERO) &&
               ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
    redirect = id_jump_i || (id_branch_i && id_eq_i);

    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    pipe_hold_o    = 1'b0;
    memwb_bubble_o = 1'b0;

    // Reset overrides everything so a pending wait is abandoned immediately.
    if (rst_i) begin
      if (freeze) begin
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        pipe_hold_o    = 1'b1;
        memwb_bubble_o = 1'b1;
      end else if (load_use) begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_bubble_o = 1'b1;
      end else if (redirect) begin
        ifid_flush_o = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (dmem_req_i && !dmem_ready_i) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 16'd1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready_i) begin
          state_d    = RUN;
          wait_cnt_d = 16'd0;
        end else if (wait_cnt_q == TIMEOUT) begin
          state_d = ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign err_o = rst_i && (state_q == ERROR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (!pc_write_o),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (ifid_flush_o),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl built with MEM_TIMEOUT=4 and CNT_W=4.
module tb_pipeline_ctrl;

  logic       clk;
  logic       rst_i;
  logic [4:0] id_rs_i, id_rt_i, ex_rt_i;
  logic       id_uses_rt_i, ex_memread_i, id_branch_i, id_eq_i, id_jump_i;
  logic       dmem_req_i, dmem_ready_i;
  logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o;
  logic       pipe_hold_o, memwb_bubble_o, err_o;
  logic [3:0] stall_cnt_o, flush_cnt_o;

  int n_pass  = 0;
  int n_total = 0;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .id_uses_rt_i   (id_uses_rt_i),
    .ex_memread_i   (ex_memread_i),
    .ex_rt_i        (ex_rt_i),
    .id_branch_i    (id_branch_i),
    .id_eq_i        (id_eq_i),
    .id_jump_i      (id_jump_i),
    .dmem_req_i     (dmem_req_i),
    .dmem_ready_i   (dmem_ready_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .pipe_hold_o    (pipe_hold_o),
    .memwb_bubble_o (memwb_bubble_o),
    .err_o          (err_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Packs {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, memwb_bubble}.
  function automatic logic [31:0] ctl();
    return {26'd0, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
            pipe_hold_o, memwb_bubble_o};
  endfunction

  localparam logic [31:0] C_DEF    = 32'b110000;
  localparam logic [31:0] C_LU     = 32'b000100;
  localparam logic [31:0] C_FREEZE = 32'b000011;
  localparam logic [31:0] C_FLUSH  = 32'b111000;

  task automatic idle();
    id_rs_i = 5'd0; id_rt_i = 5'd0; ex_rt_i = 5'd0;
    id_uses_rt_i = 1'b0; ex_memread_i = 1'b0;
    id_branch_i = 1'b0; id_eq_i = 1'b0; id_jump_i = 1'b0;
    dmem_req_i = 1'b0; dmem_ready_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
  endtask

  initial begin
    idle();
    rst_i = 1'b0;
    // Reset with a load-use pattern present: outputs must still be defaults.
    ex_memread_i = 1'b1; ex_rt_i = 5'd5; id_rs_i = 5'd5; dmem_req_i = 1'b1;
    #2;
    chk("reset_forced_ctl", ctl(), C_DEF);
    step();
    idle();
    rst_i = 1'b1;
    #1;
    chk("reset_ctl", ctl(), C_DEF);
    chk("reset_err", {31'd0, err_o}, 32'd0);
    chk("reset_stall_cnt", {28'd0, stall_cnt_o}, 32'd0);
    chk("reset_flush_cnt", {28'd0, flush_cnt_o}, 32'd0);
    $display("txn reset: ctl=%b err=%b", ctl(), err_o);

    // Load-use via rs.
    ex_memread_i = 1'b1; ex_rt_i = 5'd5; id_rs_i = 5'd5;
    #1;
    chk("loaduse_rs_ctl", ctl(), C_LU);
    step();
    idle();
    #1;
    chk("loaduse_release_ctl", ctl(), C_DEF);
    chk("loaduse_stall_cnt", {28'd0, stall_cnt_o}, 32'd1);
    $display("txn load-use rs: stall_cnt=%0d", stall_cnt_o);

    // Load-use via rt only when the ID instruction reads rt.
    ex_memread_i = 1'b1; ex_rt_i = 5'd7; id_rs_i = 5'd3; id_rt_i = 5'd7; id_uses_rt_i = 1'b1;
    #1;
    chk("loaduse_rt_ctl", ctl(), C_LU);
    id_uses_rt_i = 1'b0;
    #1;
    chk("loaduse_rt_unused_ctl", ctl(), C_DEF);
    ex_memread_i = 1'b0; id_uses_rt_i = 1'b1;
    #1;
    chk("no_memread_ctl", ctl(), C_DEF);
    step();
    idle();
    // Register zero never stalls.
    ex_memread_i = 1'b1; ex_rt_i = 5'd0; id_rs_i = 5'd0;
    #1;
    chk("reg_zero_ctl", ctl(), C_DEF);
    step();
    idle();
    #1;
    chk("rt_stall_cnt", {28'd0, stall_cnt_o}, 32'd1);
    $display("txn rt/zero: stall_cnt=%0d", stall_cnt_o);

    // Branch during load-use: stall first, then redirect.
    do_reset();
    ex_memread_i = 1'b1; ex_rt_i = 5'd5; id_rs_i = 5'd5; id_branch_i = 1'b1; id_eq_i = 1'b1;
    #1;
    chk("br_lu_cycle1_ctl", ctl(), C_LU);
    step();
    ex_memread_i = 1'b0;
    #1;
    chk("br_lu_cycle2_ctl", ctl(), C_FLUSH);
    step();
    idle();
    id_branch_i = 1'b1; id_eq_i = 1'b0;
    #1;
    chk("br_not_taken_ctl", ctl(), C_DEF);
    chk("br_flush_cnt", {28'd0, flush_cnt_o}, 32'd1);
    chk("br_stall_cnt", {28'd0, stall_cnt_o}, 32'd1);
    $display("txn branch-load-use: flush_cnt=%0d stall_cnt=%0d", flush_cnt_o, stall_cnt_o);

    // Memory wait: 3 not-ready cycles, then ready. Freeze outranks hazards.
    do_reset();
    idle();
    dmem_req_i = 1'b1; dmem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      id_jump_i = (i == 1);
      ex_memread_i = (i == 2); ex_rt_i = 5'd4; id_rs_i = 5'd4;
      #1;
      chk($sformatf("memwait_freeze%0d_ctl", i), ctl(), C_FREEZE);
      step();
    end
    idle();
    dmem_req_i = 1'b1; dmem_ready_i = 1'b1;
    #1;
    chk("memwait_release_ctl", ctl(), C_DEF);
    step();
    #1;
    chk("memwait_run_ready_ctl", ctl(), C_DEF);
    chk("memwait_stall_cnt", {28'd0, stall_cnt_o}, 32'd3);
    chk("memwait_flush_cnt", {28'd0, flush_cnt_o}, 32'd0);
    step();
    idle();
    #1;
    chk("memwait_back_to_run", ctl(), C_DEF);
    $display("txn memwait: stall_cnt=%0d", stall_cnt_o);

    // Timeout: RUN cycle + 4 MEM_WAIT not-ready cycles, then ERROR.
    do_reset();
    dmem_req_i = 1'b1; dmem_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      chk($sformatf("timeout_err_low%0d", i), {31'd0, err_o}, 32'd0);
    end
    step();
    #1;
    chk("timeout_err_high", {31'd0, err_o}, 32'd1);
    dmem_ready_i = 1'b1;
    #1;
    chk("error_freeze_ctl", ctl(), C_FREEZE);
    for (int i = 0; i < 3; i++) step();
    #1;
    chk("error_sticky", {31'd0, err_o}, 32'd1);
    chk("error_stall_cnt", {28'd0, stall_cnt_o}, 32'd8);
    $display("txn timeout: err=%b stall_cnt=%0d", err_o, stall_cnt_o);
    rst_i = 1'b0;
    #1;
    chk("error_reset_ctl", ctl(), C_DEF);
    step();
    rst_i = 1'b1;
    idle();
    #1;
    chk("post_reset_err", {31'd0, err_o}, 32'd0);
    chk("post_reset_stall_cnt", {28'd0, stall_cnt_o}, 32'd0);
    chk("post_reset_ctl", ctl(), C_DEF);
    $display("txn reset-from-error: err=%b pc_write=%b", err_o, pc_write_o);

    // Saturation of the 4-bit flush counter.
    id_jump_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 13) chk("sat_flush_cnt_14", {28'd0, flush_cnt_o}, 32'd14);
    end
    #1;
    chk("sat_flush_ctl", ctl(), C_FLUSH);
    chk("sat_flush_cnt_hold", {28'd0, flush_cnt_o}, 32'd15);
    $display("txn saturation: flush_cnt=%0d", flush_cnt_o);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
